// File: rtl/sprite_dma_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_dma_ctrl
//   Bus-mastering page copier for sprite (OAM) data. A CPU write to REG_ADDR
//   latches a source page number. The controller then halts the CPU and waits
//   for the halt acknowledge. It runs 256 read/write pairs: read page*256+idx,
//   then write the byte to DEST_ADDR. Finally it releases the bus and lets
//   the CPU run again.
//
//   Optional build macro: SPRITE_DMA_ALIGN_EN
//     When defined, the first READ is held back by one ALIGN cycle if the
//     halt acknowledge lands on an odd clock. Every transfer then starts
//     its read/write cadence on the same clock phase.
//
//   Ports:
//     clk, n_reset     clock, asynchronous active-low reset
//     snoop_addr/we/   system bus as driven by the CPU, watched for the
//     snoop_data       trigger write
//     cpu_halted       CPU has stopped and released the bus
//     cpu_rdy          0 requests a CPU halt, 1 lets the CPU run
//     bus_own          controller is driving the system bus
//     m_addr/m_we/     registered master bus outputs
//     m_oe/m_wdata
//     m_rdata          master read data, sampled at the end of a read cycle
//     busy             transfer pending or in progress
// -----------------------------------------------------------------------------
module sprite_dma_ctrl #(
   parameter int                ADDR_N    = 16,
   parameter int                DATA_N    = 8,
   parameter logic [ADDR_N-1:0] REG_ADDR  = 16'h4014,
   parameter logic [ADDR_N-1:0] DEST_ADDR = 16'h2004
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic [ADDR_N-1:0] snoop_addr,
   input  logic              snoop_we,
   input  logic [DATA_N-1:0] snoop_data,
   input  logic              cpu_halted,
   output logic              cpu_rdy,
   output logic              bus_own,
   output logic [ADDR_N-1:0] m_addr,
   output logic              m_we,
   output logic              m_oe,
   output logic [DATA_N-1:0] m_wdata,
   input  logic [DATA_N-1:0] m_rdata,
   output logic              busy
);

`ifdef SPRITE_DMA_ALIGN_EN
   typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
   // Free-running clock phase; 0 marks an even cycle.
   logic parity;
`else
   typedef enum logic [2:0] {IDLE, HALT, READ, WRITE} state_t;
`endif

   state_t            state;
   logic [DATA_N-1:0] page;
   logic [DATA_N-1:0] idx;
   logic [DATA_N-1:0] idx_nxt;
   logic [DATA_N-1:0] data_buf;
   logic              trigger;

   assign trigger = snoop_we && (snoop_addr == REG_ADDR);
   // The index wraps inside the page and never carries into the page number.
   assign idx_nxt = idx + DATA_N'(1);
   // The read data is captured straight into the register that drives the
   // write data, so the byte is on the bus for the whole WRITE cycle.
   assign m_wdata = data_buf;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state    <= IDLE;
         cpu_rdy  <= 1'b1;
         bus_own  <= 1'b0;
         m_we     <= 1'b0;
         m_oe     <= 1'b0;
         busy     <= 1'b0;
         m_addr   <= '0;
         page     <= '0;
         idx      <= '0;
         data_buf <= '0;
`ifdef SPRITE_DMA_ALIGN_EN
         parity   <= 1'b0;
`endif
      end else begin
`ifdef SPRITE_DMA_ALIGN_EN
         parity <= ~parity;
`endif
         case (state)
            IDLE: begin
               if (trigger) begin
                  page    <= snoop_data;
                  idx     <= '0;
                  state   <= HALT;
                  cpu_rdy <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            HALT: begin
               if (cpu_halted) begin
`ifdef SPRITE_DMA_ALIGN_EN
                  if (parity) begin
                     state <= ALIGN;
                  end else begin
                     state   <= READ;
                     bus_own <= 1'b1;
                     m_oe    <= 1'b1;
                     m_we    <= 1'b0;
                     m_addr  <= ADDR_N'({page, idx});
                  end
`else
                  state   <= READ;
                  bus_own <= 1'b1;
                  m_oe    <= 1'b1;
                  m_we    <= 1'b0;
                  m_addr  <= ADDR_N'({page, idx});
`endif
               end
            end
`ifdef SPRITE_DMA_ALIGN_EN
            ALIGN: begin
               state   <= READ;
               bus_own <= 1'b1;
               m_oe    <= 1'b1;
               m_we    <= 1'b0;
               m_addr  <= ADDR_N'({page, idx});
            end
`endif
            READ: begin
               data_buf <= m_rdata;
               state    <= WRITE;
               m_oe     <= 1'b0;
               m_we     <= 1'b1;
               m_addr   <= DEST_ADDR;
            end
            WRITE: begin
               idx <= idx_nxt;
               if (idx == {DATA_N{1'b1}}) begin
                  state   <= IDLE;
                  bus_own <= 1'b0;
                  m_we    <= 1'b0;
                  m_oe    <= 1'b0;
                  m_addr  <= '0;
                  cpu_rdy <= 1'b1;
                  busy    <= 1'b0;
               end else begin
                  state  <= READ;
                  m_we   <= 1'b0;
                  m_oe   <= 1'b1;
                  m_addr <= ADDR_N'({page, idx_nxt});
               end
            end
            default: begin
               state   <= IDLE;
               bus_own <= 1'b0;
               m_we    <= 1'b0;
               m_oe    <= 1'b0;
               cpu_rdy <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_dma_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sprite_dma_ctrl
//   Self-checking bench for sprite_dma_ctrl. A memory model answers reads.
//   Expected read addresses and write data are queued when a transfer is
//   triggered and popped as the controller drives the bus. A table of
//   transfer cases drives the main loop. A hand-written sequence covers
//   reset in the middle of a transfer.
// -----------------------------------------------------------------------------
module tb_sprite_dma_ctrl;

   logic        clk;
   logic        n_reset;
   logic [15:0] snoop_addr;
   logic        snoop_we;
   logic [7:0]  snoop_data;
   logic        cpu_halted;
   logic        cpu_rdy;
   logic        bus_own;
   logic [15:0] m_addr;
   logic        m_we;
   logic        m_oe;
   logic [7:0]  m_wdata;
   logic [7:0]  m_rdata;
   logic        busy;

   int nchk = 0;
   int nerr = 0;

   logic [15:0] rd_q[$];
   logic [7:0]  wr_q[$];
   bit          mon_en = 1'b0;
   int          wcount = 0;
   logic [7:0]  first_wd;
   logic [7:0]  last_wd;
   logic [15:0] last_rd;

   typedef struct {
      logic [7:0]  page;
      int          delay;
      bit          intr_halt;
      bit          intr_read;
      logic [15:0] exp_last_rd;
      logic [7:0]  exp_first_wd;
      logic [7:0]  exp_last_wd;
   } vec_t;

   vec_t tbl[4];

   sprite_dma_ctrl dut (
      .clk        (clk),
      .n_reset    (n_reset),
      .snoop_addr (snoop_addr),
      .snoop_we   (snoop_we),
      .snoop_data (snoop_data),
      .cpu_halted (cpu_halted),
      .cpu_rdy    (cpu_rdy),
      .bus_own    (bus_own),
      .m_addr     (m_addr),
      .m_we       (m_we),
      .m_oe       (m_oe),
      .m_wdata    (m_wdata),
      .m_rdata    (m_rdata),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Page 0x02 holds idx^0x5A; other pages also fold in the page number so a
   // wrong source page shows up as wrong data.
   function automatic logic [7:0] mem_model(input logic [15:0] a);
      logic [7:0] hi;
      hi = a[15:8];
      return a[7:0] ^ 8'h5A ^ ((hi == 8'h02) ? 8'h00 : hi);
   endfunction

   assign m_rdata = m_oe ? mem_model(m_addr) : 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Bus monitor: every owned cycle must be a read or a write that matches
   // the next queued expectation.
   always @(negedge clk) begin
      if (mon_en && n_reset) begin
         if (bus_own) begin
            chk("strobe_excl", {31'd0, (m_we && m_oe)}, 0);
            chk("cpu_rdy_owned", {31'd0, cpu_rdy}, 0);
            chk("owned_strobe", {31'd0, (m_we || m_oe)}, 1);
            if (m_oe) begin
               if (rd_q.size() == 0) chk("rd_unexpected", {16'd0, m_addr}, 32'hFFFF_FFFF);
               else chk("rd_addr", {16'd0, m_addr}, {16'd0, rd_q.pop_front()});
               last_rd = m_addr;
            end else if (m_we) begin
               chk("wr_addr", {16'd0, m_addr}, 32'h2004);
               if (wr_q.size() == 0) chk("wr_unexpected", {24'd0, m_wdata}, 32'hFFFF_FFFF);
               else chk("wr_data", {24'd0, m_wdata}, {24'd0, wr_q.pop_front()});
               if (wcount == 0) first_wd = m_wdata;
               last_wd = m_wdata;
               wcount++;
            end
         end else begin
            chk("strobe_unowned", {30'd0, m_we, m_oe}, 0);
         end
      end
   end

   task automatic start_trigger(input logic [7:0] page);
      for (int i = 0; i < 256; i++) begin
         rd_q.push_back({page, 8'(i)});
         wr_q.push_back(mem_model({page, 8'(i)}));
      end
      wcount = 0;
      @(negedge clk);
      snoop_addr = 16'h4014;
      snoop_data = page;
      snoop_we   = 1'b1;
      @(posedge clk);
      #1;
      snoop_we = 1'b0;
      chk("trig_cpu_rdy", {31'd0, cpu_rdy}, 0);
      chk("trig_busy", {31'd0, busy}, 1);
      chk("trig_bus_own", {31'd0, bus_own}, 0);
   endtask

   task automatic drive_intruder();
      snoop_addr = 16'h4014;
      snoop_data = 8'h07;
      snoop_we   = 1'b1;
   endtask

   task automatic run_case(input vec_t v);
      int  cyc;
      int  owned;
      bit  done;
      bit  intruded;
      start_trigger(v.page);
      for (int d = 0; d < v.delay; d++) begin
         @(negedge clk);
         if (v.intr_halt && d == 0) drive_intruder();
         else snoop_we = 1'b0;
      end
      @(negedge clk);
      snoop_we   = 1'b0;
      cpu_halted = 1'b1;
      cyc = 0; owned = 0; done = 1'b0; intruded = 1'b0;
      while (!done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (bus_own) begin
            owned++;
            if (v.intr_read && !intruded && m_oe && owned > 4) begin
               drive_intruder();
               intruded = 1'b1;
            end else begin
               snoop_we = 1'b0;
            end
         end else if (owned > 0) begin
            done = 1'b1;
         end
      end
      snoop_we = 1'b0;
      chk("release_seen", {31'd0, done}, 1);
      chk("owned_cycles", owned, 512);
`ifdef SPRITE_DMA_ALIGN_EN
      chk("release_lat", {31'd0, (cyc == 513 || cyc == 514)}, 1);
`else
      chk("release_lat", cyc, 513);
`endif
      chk("done_cpu_rdy", {31'd0, cpu_rdy}, 1);
      chk("done_busy", {31'd0, busy}, 0);
      chk("writes_total", wcount, 256);
      chk("rd_q_left", rd_q.size(), 0);
      chk("wr_q_left", wr_q.size(), 0);
      chk("last_rd_addr", {16'd0, last_rd}, {16'd0, v.exp_last_rd});
      chk("first_wdata", {24'd0, first_wd}, {24'd0, v.exp_first_wd});
      chk("last_wdata", {24'd0, last_wd}, {24'd0, v.exp_last_wd});
      cpu_halted = 1'b0;
      rd_q.delete();
      wr_q.delete();
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int   k;
      vec_t post;
      tbl[0] = '{8'h02, 3, 1'b0, 1'b0, 16'h02FF, 8'h5A, 8'hA5};
      tbl[1] = '{8'hFF, 1, 1'b0, 1'b0, 16'hFFFF, 8'hA5, 8'h5A};
      tbl[2] = '{8'h05, 2, 1'b1, 1'b1, 16'h05FF, 8'h5F, 8'hA0};
      tbl[3] = '{8'h00, 0, 1'b0, 1'b0, 16'h00FF, 8'h5A, 8'hA5};

      n_reset    = 1'b0;
      snoop_addr = 16'h0000;
      snoop_we   = 1'b0;
      snoop_data = 8'h00;
      cpu_halted = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cpu_rdy", {31'd0, cpu_rdy}, 1);
      chk("rst_bus_own", {31'd0, bus_own}, 0);
      chk("rst_strobes", {30'd0, m_we, m_oe}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_m_addr", {16'd0, m_addr}, 0);
      chk("rst_m_wdata", {24'd0, m_wdata}, 0);

      @(negedge clk);
      n_reset = 1'b1;
      mon_en  = 1'b1;

      // Near-miss bus traffic must not start a transfer.
      @(negedge clk);
      snoop_addr = 16'h4015; snoop_data = 8'h02; snoop_we = 1'b1;
      @(negedge clk);
      snoop_addr = 16'h4014; snoop_we = 1'b0;
      @(negedge clk);
      snoop_addr = 16'h0000;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("idle_cpu_rdy", {31'd0, cpu_rdy}, 1);
         chk("idle_bus_own", {31'd0, bus_own}, 0);
         chk("idle_busy", {31'd0, busy}, 0);
      end

      for (int t = 0; t < 4; t++) run_case(tbl[t]);

      // Reset in the middle of a transfer releases the bus at once.
      start_trigger(8'h03);
      @(negedge clk);
      cpu_halted = 1'b1;
      k = 0;
      while (wcount < 100 && k < 1000) begin
         @(posedge clk);
         k++;
      end
      chk("wait_wr100", {31'd0, (wcount >= 100)}, 1);
      @(negedge clk);
      #2;
      n_reset = 1'b0;
      mon_en  = 1'b0;
      #1;
      chk("arst_bus_own", {31'd0, bus_own}, 0);
      chk("arst_strobes", {30'd0, m_we, m_oe}, 0);
      chk("arst_cpu_rdy", {31'd0, cpu_rdy}, 1);
      chk("arst_busy", {31'd0, busy}, 0);
      rd_q.delete();
      wr_q.delete();
      cpu_halted = 1'b0;
      @(negedge clk);
      n_reset = 1'b1;
      mon_en  = 1'b1;
      post = '{8'h04, 2, 1'b0, 1'b0, 16'h04FF, 8'h5E, 8'hA1};
      run_case(post);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
